// File: rtl/acc_transfer_ctrl.sv
// acc_transfer_ctrl
//   Moves one accelerator's data block: reads `filesize` words starting at
//   `offset` and feeds them to the selected accelerator, then writes the same
//   number of result words to the block that follows the input block in RAM.
//   Returns per-channel read/write done flags to the high-level control array.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   {fft,fir,iir}_put_req      channel wants input data (read phase)
//   {fft,fir,iir}_get_req      channel has results (write phase)
//   offset, filesize           base address / word count, latched at start
//   acc_out_valid              accelerator presents a result word this cycle
//   ram_addr                   RAM word address
//   ram_read_enable            one RAM read this cycle
//   ram_write_enable           one RAM write this cycle
//   acc_in_valid               RAM read data valid (read enable delayed 1)
//   {fft,fir,iir}_read_done    input block fully read for that channel
//   {fft,fir,iir}_write_done   result block fully written for that channel
module acc_transfer_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fft_put_req,
  input  logic              fir_put_req,
  input  logic              iir_put_req,
  input  logic              fft_get_req,
  input  logic              fir_get_req,
  input  logic              iir_get_req,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] filesize,
  input  logic              acc_out_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic              acc_in_valid,
  output logic              fft_read_done,
  output logic              fir_read_done,
  output logic              iir_read_done,
  output logic              fft_write_done,
  output logic              fir_write_done,
  output logic              iir_write_done
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [2:0]        ch_oh;      // selected channel, one-hot {iir,fir,fft}
  logic [ADDR_W-1:0] off_q, fs_q, rd_cnt, wr_cnt, addr_q;
  logic              re_q, aiv_q;
  logic [2:0]        rd_done_q, wr_done_q;

  logic [2:0]        put_v, get_v, put_first;
  logic              sel_active, abort, wr_fire;
  logic [ADDR_W-1:0] wr_addr;

  assign put_v = {iir_put_req, fir_put_req, fft_put_req};
  assign get_v = {iir_get_req, fir_get_req, fft_get_req};

  // Lowest set bit wins: FFT > FIR > IIR.
  assign put_first = put_v & (~put_v + 3'd1);

  // The selected channel keeps the transfer alive while either request is up.
  assign sel_active = |((put_v | get_v) & ch_oh);
  assign abort      = (state inside {LOAD, READ, WRITE}) && !sel_active;

  // Writes follow acc_out_valid in the same cycle so a result word is stored
  // the cycle it is presented; the address register only tracks the last
  // issued access so the bus holds steady through valid gaps.
  assign wr_fire  = (state == WRITE) && acc_out_valid && sel_active;
  assign wr_addr  = off_q + fs_q + wr_cnt;
  assign ram_addr = wr_fire ? wr_addr : addr_q;

  assign ram_read_enable  = re_q;
  assign ram_write_enable = wr_fire;
  assign acc_in_valid     = aiv_q;

  assign fft_read_done  = rd_done_q[0];
  assign fir_read_done  = rd_done_q[1];
  assign iir_read_done  = rd_done_q[2];
  assign fft_write_done = wr_done_q[0];
  assign fir_write_done = wr_done_q[1];
  assign iir_write_done = wr_done_q[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ch_oh     <= '0;
      off_q     <= '0;
      fs_q      <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      addr_q    <= '0;
      re_q      <= 1'b0;
      aiv_q     <= 1'b0;
      rd_done_q <= '0;
      wr_done_q <= '0;
    end else begin
      aiv_q <= re_q;
      if (abort) begin
        // Partial transfer is dropped; nothing further reaches RAM.
        state     <= IDLE;
        re_q      <= 1'b0;
        rd_done_q <= '0;
        wr_done_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (|put_v) begin
              ch_oh <= put_first;
              off_q <= offset;
              fs_q  <= filesize;
              state <= LOAD;
            end
          end
          LOAD: begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            if (fs_q == '0) begin
              rd_done_q <= ch_oh;
              wr_done_q <= ch_oh;
              state     <= DONE;
            end else begin
              re_q   <= 1'b1;
              addr_q <= off_q;
              state  <= READ;
            end
          end
          READ: begin
            // rd_cnt is the index of the read on the bus this cycle.
            if (rd_cnt == fs_q - ADDR_W'(1)) begin
              re_q      <= 1'b0;
              rd_done_q <= ch_oh;
              state     <= WRITE;
            end else begin
              rd_cnt <= rd_cnt + ADDR_W'(1);
              addr_q <= off_q + rd_cnt + ADDR_W'(1);
            end
          end
          WRITE: begin
            if (wr_fire) begin
              addr_q <= wr_addr;
              wr_cnt <= wr_cnt + ADDR_W'(1);
              if (wr_cnt == fs_q - ADDR_W'(1)) begin
                wr_done_q <= ch_oh;
                state     <= DONE;
              end
            end
          end
          DONE: begin
            if (!sel_active) begin
              rd_done_q <= '0;
              wr_done_q <= '0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
